lc3_mem_access: RTL
===================

# lc3_mem_access

Memory-side responder for the LC-3 processor controller. Watches the controller's 4-bit `state`. Runs one single-word request/acknowledge transaction on the external memory port for each memory state: Fetch, Indirect Read, Read Memory, Write Memory. Signals the end of each transaction on `complete`, and drives `complete` directly for non-memory states. Latches the fetched instruction, loaded data and indirect pointer for the Decode, Execute and Writeback blocks.

## Interface
- `WIDTH`, 16, width of addresses and data words.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `state`  in  4  current controller state.
- `pc`  in  WIDTH  program counter, the Fetch address.
- `addr_in`  in  WIDTH  effective address from the Compute Memory Address step.
- `wdata`  in  WIDTH  store data from the register file.
- `complete`  out  1  current state finished; controller advances at this edge.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = write, 0 = read; registered, valid while `mem_req`=1.
- `mem_addr`  out  WIDTH  request address, registered.
- `mem_wdata`  out  WIDTH  write data, registered.
- `mem_rdata`  in  WIDTH  read data; valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  memory acknowledge.
- `ir`  out  WIDTH  instruction register, loaded on Fetch completion.
- `mem_dout`  out  WIDTH  load data, loaded on Read Memory completion.
- `err`  out  1  sticky; set when `state` is 4'b1111, cleared only by reset.

## Operation
- Memory states:
  - 4'b0001 Fetch: read at `pc`.
  - 4'b0111 Indirect Read: read at `addr_in`.
  - 4'b0110 Read Memory: read.
  - 4'b1000 Write Memory: write.
- Address for Read Memory and Write Memory: `ind_valid` ? `ind_ptr` : `addr_in`.
- `ind_ptr` is a WIDTH-bit register loaded from `mem_rdata` when an Indirect Read completes; `ind_valid` is set at the same edge.
- `ind_valid` is cleared when a Fetch completes.
- Non-memory states 0010, 0011, 0100, 0101, 1001, 1010: `complete`=1 combinationally while in IDLE.
- All other state codes: `complete`=0.
- 4'b1111 additionally sets `err`.
- Internal FSM, 3 states:
  - IDLE: if `state` is a memory state, at the next edge go to WAIT and register `mem_req`=1, `mem_we` (1 only for 1000), `mem_addr` and `mem_wdata`=`wdata`.
  - WAIT: hold `mem_req` and the request fields stable until `mem_ack`=1 is sampled. At that edge:
    - capture `mem_rdata` into `ir`, `ind_ptr` or `mem_dout` according to `state`; writes capture nothing;
    - drop `mem_req`;
    - go to DONE.
  - DONE: `complete`=1 for exactly one cycle, then IDLE unconditionally.
- `complete` = (FSM==DONE) | (FSM==IDLE & `state` is a non-memory valid state).
- Back-to-back memory states (Indirect Read followed by Read Memory or Write Memory): the controller changes `state` at the DONE edge, so IDLE sees the new state and starts a fresh transaction. No edge detection is required.
- `mem_ack` sampled outside WAIT is ignored.
- A change of `state` during WAIT is not expected. The transaction finishes regardless, and captures are steered by `state` at the ack edge.
- Reset values:
  - FSM = IDLE;
  - `mem_req`, `mem_we`, `err`, `ind_valid` = 0;
  - `mem_addr`, `mem_wdata`, `ir`, `mem_dout`, `ind_ptr` = 0.
- Reset during WAIT or DONE: the request is abandoned and `mem_req`=0 after the reset edge. The memory must tolerate a withdrawn request. No capture occurs.

## Timing
- Memory state entered in cycle 0 → `mem_req`=1 from cycle 1.
- `mem_ack` in cycle k ≥ 1 → DONE and `complete`=1 in cycle k+1 → next controller state in cycle k+2.
- Minimum latency, with ack in cycle 1: `complete` in cycle 2, 3 cycles per memory state.
- Non-memory state: 1 cycle, `complete` with zero latency.
- `ir`, `mem_dout` and `ind_ptr` update at the ack edge, so they are valid in the DONE cycle.
- `mem_req` is never high for two consecutive transactions without at least one IDLE cycle (DONE+IDLE gap ≥ 2 cycles).

## Test plan
- Fetch, zero-wait: `state`=0001, `pc`=16'h3000, memory acks in the first request cycle with 16'h1234 → `mem_req`=1, `mem_we`=0, `mem_addr`=16'h3000 in cycle 1; `complete`=1 in cycle 2; `ir`=16'h1234.
- Wait states: `state`=1000, `addr_in`=16'h4000, `wdata`=16'hBEEF, ack delayed 3 cycles → `mem_req` and the fields stay stable for 4 cycles with `mem_we`=1; `complete` exactly 1 cycle; `mem_dout` unchanged.
- Indirect chain: 0111 at `addr_in`=16'h5000 returns 16'h6000, then 0110 returns 16'h00AA → second `mem_addr`=16'h6000, `mem_dout`=16'h00AA. After the next Fetch completes, a 0110 uses `addr_in` again.
- Non-memory states 0010, 0011, 1001, 1010 → `complete`=1 in the same cycle; `mem_req` stays 0.
- Invalid: `state`=1111 → `complete`=0, `err`=1 and it stays 1 after the state changes; reset clears it.
- Reset mid-WAIT: assert `reset` while `mem_req`=1 → next cycle `mem_req`=0, FSM IDLE, `ir`, `mem_dout` and `ind_ptr` = 0; a late `mem_ack` is ignored.

Source files
------------

// File: rtl/lc3_mem_access.sv
// Memory-side responder for the LC-3 controller: one request/acknowledge
// transaction per memory state, plus latching of IR, load data and indirect pointer.
module lc3_mem_access #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] wdata,
    output logic             complete,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] mem_dout,
    output logic             err
);

    localparam logic [3:0] ST_FETCH   = 4'b0001;
    localparam logic [3:0] ST_IND     = 4'b0111;
    localparam logic [3:0] ST_READ    = 4'b0110;
    localparam logic [3:0] ST_WRITE   = 4'b1000;
    localparam logic [3:0] ST_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    function automatic logic is_mem_state(input logic [3:0] st);
        case (st)
            ST_FETCH, ST_IND, ST_READ, ST_WRITE: is_mem_state = 1'b1;
            default:                             is_mem_state = 1'b0;
        endcase
    endfunction

    function automatic logic is_plain_state(input logic [3:0] st);
        case (st)
            4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1010: is_plain_state = 1'b1;
            default:                                              is_plain_state = 1'b0;
        endcase
    endfunction

    fsm_t             fsm_q, fsm_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mem_dout_q, mem_dout_d;
    logic [WIDTH-1:0] ind_ptr_q, ind_ptr_d;
    logic             ind_valid_q, ind_valid_d;
    logic             err_q, err_d;

    // State register and all datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {WIDTH{1'b0}};
            mem_wdata_q <= {WIDTH{1'b0}};
            ir_q        <= {WIDTH{1'b0}};
            mem_dout_q  <= {WIDTH{1'b0}};
            ind_ptr_q   <= {WIDTH{1'b0}};
            ind_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ir_q        <= ir_d;
            mem_dout_q  <= mem_dout_d;
            ind_ptr_q   <= ind_ptr_d;
            ind_valid_q <= ind_valid_d;
            err_q       <= err_d;
        end
    end

    // Next FSM state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (is_mem_state(state)) begin
                    fsm_d = S_WAIT;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    fsm_d = S_DONE;
                end else begin
                    fsm_d = S_WAIT;
                end
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Request launch, read-data steering and completion
    always_comb begin
        complete    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mem_dout_d  = mem_dout_q;
        ind_ptr_d   = ind_ptr_q;
        ind_valid_d = ind_valid_q;
        err_d       = err_q | (state == ST_INVALID);
        case (fsm_q)
            S_IDLE: begin
                complete = is_plain_state(state);
                if (is_mem_state(state)) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (state == ST_WRITE);
                    mem_wdata_d = wdata;
                    // Loads and stores follow a pending indirect pointer
                    case (state)
                        ST_FETCH: mem_addr_d = pc;
                        ST_IND:   mem_addr_d = addr_in;
                        default:  mem_addr_d = ind_valid_q ? ind_ptr_q : addr_in;
                    endcase
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    case (state)
                        ST_FETCH: begin
                            ir_d        = mem_rdata;
                            ind_valid_d = 1'b0;
                        end
                        ST_IND: begin
                            ind_ptr_d   = mem_rdata;
                            ind_valid_d = 1'b1;
                        end
                        ST_READ: mem_dout_d = mem_rdata;
                        default: begin
                        end
                    endcase
                end else begin
                    mem_req_d = mem_req_q;
                end
            end
            S_DONE:  complete = 1'b1;
            default: complete = 1'b0;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ir        = ir_q;
    assign mem_dout  = mem_dout_q;
    assign err       = err_q;

endmodule
